// File: rtl/cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder
//   Receive-side command parser for the system controller. It takes bytes
//   from the UART RX path, which are already synchronized into CLK, and
//   assembles command frames. For each frame it issues register-file and ALU
//   strobes.
//
//   Frames (the first byte is the command):
//     AA addr data  : register-file write
//     BB addr       : register-file read
//     CC opa opb fn : write opa->RF[0], write opb->RF[1], then ALU op fn
//     DD fn         : ALU op on the operands already in the register file
//
//   Ports
//     CLK, RST          clock, asynchronous active-low reset
//     RX_P_DATA         received byte
//     RX_D_VLD          one-cycle strobe that qualifies RX_P_DATA
//     RX_ERR            parity/framing error for the current byte
//     WrEn, RdEn        single-cycle register-file strobes
//     Address, WrData   register-file address and write data (held between strobes)
//     ALU_EN, ALU_FUN   single-cycle ALU strobe and function (ALU_FUN held)
//     CLK_EN            ALU clock-gate enable
//     BUSY              a frame is in progress
//     CMD_DONE, CMD_ERR single-cycle completion / error pulses
//
//   Build option: define CMD_TIMEOUT_EN to add an inter-byte watchdog. The
//   watchdog drops a stalled frame after TIMEOUT_CYCLES cycles.
// ---------------------------------------------------------------------------
module cmd_frame_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_SIZE      = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_SIZE-1:0]  Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [FUNC_WIDTH-1:0] ALU_FUN,
    output logic                  CLK_EN,
    output logic                  BUSY,
    output logic                  CMD_DONE,
    output logic                  CMD_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_ALU_OPA,
        S_ALU_OPB,
        S_ALU_FUN
    } state_t;

    state_t                state, state_d;
    logic [ADDR_SIZE-1:0]  wr_addr, wr_addr_d;
    logic                  wr_en_d, rd_en_d, alu_en_d, done_d, err_d, clk_en_d;
    logic [ADDR_SIZE-1:0]  addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [FUNC_WIDTH-1:0] fun_d;
    logic                  byte_ok, byte_bad;

    assign byte_ok  = RX_D_VLD && !RX_ERR;
    assign byte_bad = RX_D_VLD &&  RX_ERR;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          timeout;

    // A byte that arrives in the timeout cycle takes priority, so the
    // watchdog only fires on a cycle with no RX_D_VLD.
    assign timeout = (state != S_IDLE) && !RX_D_VLD &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            to_cnt <= '0;
        else if (RX_D_VLD || state == S_IDLE || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    // No watchdog in this build: a partial frame waits indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // State and all outputs are registered together. As a result, every
    // strobe appears in the cycle after the byte that caused it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            wr_addr  <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
            ALU_EN   <= 1'b0;
            ALU_FUN  <= '0;
            CLK_EN   <= 1'b0;
            BUSY     <= 1'b0;
            CMD_DONE <= 1'b0;
            CMD_ERR  <= 1'b0;
        end else begin
            state    <= state_d;
            wr_addr  <= wr_addr_d;
            WrEn     <= wr_en_d;
            RdEn     <= rd_en_d;
            Address  <= addr_d;
            WrData   <= wdata_d;
            ALU_EN   <= alu_en_d;
            ALU_FUN  <= fun_d;
            CLK_EN   <= clk_en_d;
            BUSY     <= (state_d != S_IDLE);
            CMD_DONE <= done_d;
            CMD_ERR  <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        wr_addr_d = wr_addr;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        addr_d    = Address;
        wdata_d   = WrData;
        fun_d     = ALU_FUN;

        if (byte_bad) begin
            // A corrupted byte aborts the frame from any state.
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (byte_ok) begin
            // Inside a frame every byte is payload, including the
            // command codes.
            unique case (state)
                S_IDLE: begin
                    if (RX_P_DATA == CMD_WR)
                        state_d = S_WR_ADDR;
                    else if (RX_P_DATA == CMD_RD)
                        state_d = S_RD_ADDR;
                    else if (RX_P_DATA == CMD_ALU_OP)
                        state_d = S_ALU_OPA;
                    else if (RX_P_DATA == CMD_ALU_NO)
                        state_d = S_ALU_FUN;
                    else
                        err_d = 1'b1;
                end
                S_WR_ADDR: begin
                    wr_addr_d = RX_P_DATA[ADDR_SIZE-1:0];
                    state_d   = S_WR_DATA;
                end
                S_WR_DATA: begin
                    wr_en_d = 1'b1;
                    addr_d  = wr_addr;
                    wdata_d = RX_P_DATA;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                S_RD_ADDR: begin
                    rd_en_d = 1'b1;
                    addr_d  = RX_P_DATA[ADDR_SIZE-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                S_ALU_OPA: begin
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_SIZE'(0);
                    wdata_d = RX_P_DATA;
                    state_d = S_ALU_OPB;
                end
                S_ALU_OPB: begin
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_SIZE'(1);
                    wdata_d = RX_P_DATA;
                    state_d = S_ALU_FUN;
                end
                S_ALU_FUN: begin
                    alu_en_d = 1'b1;
                    fun_d    = RX_P_DATA[FUNC_WIDTH-1:0];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
`ifdef CMD_TIMEOUT_EN
        end else if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
`endif
        end

        // The ALU clock runs while waiting for the function byte and
        // through the ALU_EN cycle. It stops on the cycle after ALU_EN.
        clk_en_d = (state_d == S_ALU_FUN) || alu_en_d;
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
module tb_cmd_frame_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic       RX_ERR = 1'b0;
    logic       WrEn, RdEn, ALU_EN, CLK_EN, BUSY, CMD_DONE, CMD_ERR;
    logic [3:0] Address, ALU_FUN;
    logic [7:0] WrData;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    cmd_frame_decoder dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_ERR(RX_ERR), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
        .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .BUSY(BUSY), .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // ---- frame-level model: bytes collected so far in the current frame ----
    logic [7:0] frame[$];
    logic       e_wr, e_rd, e_alu, e_done, e_err, e_clken, e_busy;
    logic [3:0] e_addr, e_fun;
    logic [7:0] e_wdata;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame.delete();
            {e_wr, e_rd, e_alu, e_done, e_err, e_clken, e_busy} = '0;
            e_addr = '0; e_fun = '0; e_wdata = '0;
        end else begin
            {e_wr, e_rd, e_alu, e_done, e_err} = '0;
            if (RX_D_VLD && RX_ERR) begin
                frame.delete();
                e_err = 1'b1;
            end else if (RX_D_VLD) begin
                if (frame.size() == 0) begin
                    if (RX_P_DATA inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})
                        frame.push_back(RX_P_DATA);
                    else
                        e_err = 1'b1;
                end else begin
                    frame.push_back(RX_P_DATA);
                    case (frame[0])
                        8'hAA: if (frame.size() == 3) begin
                            e_wr = 1; e_addr = frame[1][3:0]; e_wdata = frame[2];
                            e_done = 1; frame.delete();
                        end
                        8'hBB: begin
                            e_rd = 1; e_addr = frame[1][3:0];
                            e_done = 1; frame.delete();
                        end
                        8'hCC: if (frame.size() == 2) begin
                            e_wr = 1; e_addr = 4'd0; e_wdata = frame[1];
                        end else if (frame.size() == 3) begin
                            e_wr = 1; e_addr = 4'd1; e_wdata = frame[2];
                        end else begin
                            e_alu = 1; e_fun = frame[3][3:0];
                            e_done = 1; frame.delete();
                        end
                        default: begin // DD
                            e_alu = 1; e_fun = frame[1][3:0];
                            e_done = 1; frame.delete();
                        end
                    endcase
                end
            end
            e_busy  = (frame.size() != 0);
            // waiting for a function byte, or in the ALU strobe cycle
            e_clken = e_alu ||
                      (frame.size() == 1 && frame[0] == 8'hDD) ||
                      (frame.size() == 3 && frame[0] == 8'hCC);
        end
    end

    // ---- every-cycle compare against the model ----
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("WrEn", {7'd0, WrEn}, {7'd0, e_wr});
            cmp("RdEn", {7'd0, RdEn}, {7'd0, e_rd});
            cmp("ALU_EN", {7'd0, ALU_EN}, {7'd0, e_alu});
            cmp("CMD_DONE", {7'd0, CMD_DONE}, {7'd0, e_done});
            cmp("CMD_ERR", {7'd0, CMD_ERR}, {7'd0, e_err});
            cmp("CLK_EN", {7'd0, CLK_EN}, {7'd0, e_clken});
            cmp("BUSY", {7'd0, BUSY}, {7'd0, e_busy});
            cmp("Address", {4'd0, Address}, {4'd0, e_addr});
            cmp("WrData", WrData, e_wdata);
            cmp("ALU_FUN", {4'd0, ALU_FUN}, {4'd0, e_fun});
        end
    end

    // One call = one clock cycle of stimulus, driven just after the edge.
    task automatic cyc(input logic vld, input logic [7:0] d, input logic err);
        @(posedge CLK);
        #1;
        RX_D_VLD  = vld;
        RX_P_DATA = d;
        RX_ERR    = err;
    endtask

    task automatic byte_in(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    // Hand-computed literal checks. Each is taken 1 time unit after the
    // edge that samples the previous byte.
    task automatic pin(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp(name, act, exp);
    endtask

    task automatic pin_all_zero(input string tag);
        pin({tag, ".strobes"}, {1'b0, WrEn, RdEn, ALU_EN, CLK_EN, BUSY, CMD_DONE, CMD_ERR}, 8'h00);
        pin({tag, ".Address"}, {4'd0, Address}, 8'h00);
        pin({tag, ".WrData"}, WrData, 8'h00);
        pin({tag, ".ALU_FUN"}, {4'd0, ALU_FUN}, 8'h00);
    endtask

    initial begin
        #12;
        pin_all_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // write frame AA 04 09, back-to-back bytes
        byte_in(8'hAA); byte_in(8'h04); byte_in(8'h09);
        idle(1);
        pin("wr.WrEn", {7'd0, WrEn}, 8'h01);
        pin("wr.Address", {4'd0, Address}, 8'h04);
        pin("wr.WrData", WrData, 8'h09);
        pin("wr.DONE", {7'd0, CMD_DONE}, 8'h01);
        pin("wr.BUSY", {7'd0, BUSY}, 8'h00);
        idle(1);
        pin("wr.WrEn_1cyc", {7'd0, WrEn}, 8'h00);
        pin("wr.hold", WrData, 8'h09);

        // read frame BB 04
        byte_in(8'hBB); byte_in(8'h04);
        idle(1);
        pin("rd.RdEn", {7'd0, RdEn}, 8'h01);
        pin("rd.WrEn", {7'd0, WrEn}, 8'h00);
        pin("rd.Address", {4'd0, Address}, 8'h04);
        pin("rd.DONE", {7'd0, CMD_DONE}, 8'h01);

        // ALU with operands CC 3C 32 02
        byte_in(8'hCC); byte_in(8'h3C); byte_in(8'h32);
        pin("opa.WrEn", {7'd0, WrEn}, 8'h01);
        pin("opa.Address", {4'd0, Address}, 8'h00);
        pin("opa.WrData", WrData, 8'h3C);
        byte_in(8'h02);
        pin("opb.Address", {4'd0, Address}, 8'h01);
        pin("opb.WrData", WrData, 8'h32);
        pin("opb.CLK_EN", {7'd0, CLK_EN}, 8'h01);
        idle(1);
        pin("alu.ALU_EN", {7'd0, ALU_EN}, 8'h01);
        pin("alu.ALU_FUN", {4'd0, ALU_FUN}, 8'h02);
        pin("alu.CLK_EN", {7'd0, CLK_EN}, 8'h01);
        idle(1);
        pin("alu.CLK_EN_off", {7'd0, CLK_EN}, 8'h00);

        // ALU without operands, function upper bits ignored
        byte_in(8'hDD); byte_in(8'h31);
        idle(1);
        pin("dd.ALU_FUN", {4'd0, ALU_FUN}, 8'h01);
        pin("dd.WrEn", {7'd0, WrEn}, 8'h00);
        idle(2);

        // unknown command byte in IDLE
        byte_in(8'h55);
        idle(1);
        pin("unk.ERR", {7'd0, CMD_ERR}, 8'h01);
        pin("unk.BUSY", {7'd0, BUSY}, 8'h00);
        idle(1);

        // RX_ERR on the data byte of a write
        byte_in(8'hAA); byte_in(8'h04); cyc(1'b1, 8'h09, 1'b1);
        idle(1);
        pin("rxerr.ERR", {7'd0, CMD_ERR}, 8'h01);
        pin("rxerr.WrEn", {7'd0, WrEn}, 8'h00);
        pin("rxerr.BUSY", {7'd0, BUSY}, 8'h00);

        // command codes used as payload; address upper bits dropped
        byte_in(8'hAA); byte_in(8'hF2); byte_in(8'hAA);
        byte_in(8'hBB); byte_in(8'hF7);
        pin("payload.WrData", WrData, 8'hAA);
        pin("payload.Address", {4'd0, Address}, 8'h02);
        idle(1);
        pin("rdhi.Address", {4'd0, Address}, 8'h07);

        // spaced bytes with idle gaps inside a frame
        byte_in(8'hCC); idle(3); byte_in(8'h11); idle(2);
        byte_in(8'h22); idle(4); byte_in(8'h0F); idle(2);
        pin("gap.ALU_FUN", {4'd0, ALU_FUN}, 8'h0F);

        // reset mid-frame after CC 3C
        byte_in(8'hCC); byte_in(8'h3C); idle(1);
        RST = 1'b0;
        #2;
        pin_all_zero("midrst");
        idle(2);
        RST = 1'b1;
        byte_in(8'hDD); byte_in(8'h01);
        idle(1);
        pin("postrst.ALU_EN", {7'd0, ALU_EN}, 8'h01);
        pin("postrst.ALU_FUN", {4'd0, ALU_FUN}, 8'h01);
        pin("postrst.WrData", WrData, 8'h00);
        idle(3);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
